// File: rtl/slice_serial_adder_if.sv
// Handshake and operand/result bus for slice_serial_adder.
// master drives requests (start/sub/a/b/cin); slave is the adder itself.
interface slice_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/slice_serial_adder.sv
// slice_serial_adder: multi-cycle add/sub, SLICE bits per clock through a
// registered carry. IDLE -> RUN (NSLICE cycles) -> DONE (one-cycle pulse).
// A start in DONE begins the next operation with no bubble.
// Optional macro SLICE_ADDER_SAT_EN: saturate sum on signed overflow.
module slice_serial_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    slice_serial_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // operand A, shifted right a slice per cycle
    logic [WIDTH-1:0] b_q, b_d;        // operand B' (B or ~B), shifted likewise
    logic [WIDTH-1:0] res_q, res_d;    // partial result, filled from the top
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d; // sign bits kept for the overflow test,
    logic             b_msb_q, b_msb_d; // since the operand regs get shifted away
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;

    logic             accept;
    logic             last;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] res_next;
    logic             raw_ovf;
    logic [WIDTH-1:0] b_in;

    // start is honoured whenever no operation is in flight (IDLE or DONE)
    assign accept = bus.start && (state_q != S_RUN);
    assign last   = (k_q == KLAST);
    assign b_in   = bus.sub ? ~bus.b : bus.b;

    // one slice of the add plus the result-register shift-in
    always_comb begin
        slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry_q};
        // shift form keeps this legal when NSLICE == 1
        res_next  = (res_q >> SLICE)
                  | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
        raw_ovf   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state and result registers
    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
        bus.ovf  = ovf_q;
    end

    // datapath next-state: capture on accept, slice-step in RUN, publish on last slice
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = b_in;
            carry_d = bus.sub ? 1'b1 : bus.cin;
            a_msb_d = bus.a[WIDTH-1];
            b_msb_d = b_in[WIDTH-1];
            res_d   = '0;
            k_d     = '0;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> SLICE;
            b_d     = b_q >> SLICE;
            carry_d = slice_sum[SLICE];
            res_d   = res_next;
            k_d     = k_q + KW'(1);
            if (last) begin
                cout_d = slice_sum[SLICE];
                ovf_d  = raw_ovf;
`ifdef SLICE_ADDER_SAT_EN
                if (raw_ovf)
                    sum_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    sum_d = res_next;
`else
                sum_d = res_next;
`endif
            end
        end
    end

    // datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end
endmodule

// File: tb/tb_slice_serial_adder.sv
// Directed bench for slice_serial_adder, WIDTH=16 SLICE=4.
module tb_slice_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef SLICE_ADDER_SAT_EN
    localparam logic [15:0] EXP_7FFF_P1  = 16'h7FFF;
    localparam logic [15:0] EXP_8000_M1  = 16'h8000;
    localparam logic [15:0] EXP_8000_PFF = 16'h8000;
`else
    localparam logic [15:0] EXP_7FFF_P1  = 16'h8000;
    localparam logic [15:0] EXP_8000_M1  = 16'h7FFF;
    localparam logic [15:0] EXP_8000_PFF = 16'h7FFF;
`endif

    slice_serial_adder_if #(.WIDTH(16)) ifc ();

    slice_serial_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Issue one start and wait (bounded) for done; returns in the DONE cycle.
    task automatic run_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, output int bcnt, output bit got);
        @(negedge clk);
        ifc.start = 1'b1; ifc.sub = s; ifc.a = av; ifc.b = bv; ifc.cin = c;
        @(negedge clk);
        ifc.start = 1'b0; ifc.sub = ~s; ifc.a = 16'($urandom); ifc.b = 16'($urandom); ifc.cin = ~c;
        bcnt = 0; got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ifc.done) begin got = 1'b1; break; end
            if (ifc.busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", ifc.done); end
        checks++; if (ifc.sum !== 16'h0) begin errors++; $display("FAIL rst_sum got %h want 0000", ifc.sum); end
        checks++; if ({ifc.cout, ifc.ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {ifc.cout, ifc.ovf}); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int bc; bit got;
        run_op(1'b0, 16'h1234, 16'h0FF1, 1'b0, bc, got);
        checks++; if (!got) begin errors++; $display("FAIL add1_done got none want pulse"); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL add1_busy got %0d want 4", bc); end
        checks++; if ({ifc.cout, ifc.ovf, ifc.sum} !== {2'b00, 16'h2225}) begin errors++;
            $display("FAIL add1_res got %b%b %h want 00 2225", ifc.cout, ifc.ovf, ifc.sum); end
        @(negedge clk);
        checks++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin errors++;
            $display("FAIL add1_pulse got done=%b busy=%b want 0 0", ifc.done, ifc.busy); end
        checks++; if (ifc.sum !== 16'h2225) begin errors++; $display("FAIL add1_hold got %h want 2225", ifc.sum); end

        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, bc, got);
        checks++; if ({got, ifc.cout, ifc.ovf, ifc.sum} !== {3'b110, 16'h0000}) begin errors++;
            $display("FAIL add_wrap got %b%b%b %h want 110 0000", got, ifc.cout, ifc.ovf, ifc.sum); end

        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, bc, got);
        checks++; if ({got, ifc.cout, ifc.ovf, ifc.sum} !== {3'b101, EXP_7FFF_P1}) begin errors++;
            $display("FAIL add_ovf got %b%b%b %h want 101 %h", got, ifc.cout, ifc.ovf, ifc.sum, EXP_7FFF_P1); end

        run_op(1'b0, 16'h00FF, 16'h0F00, 1'b1, bc, got);
        checks++; if ({got, ifc.cout, ifc.ovf, ifc.sum} !== {3'b100, 16'h1000}) begin errors++;
            $display("FAIL add_cin got %b%b%b %h want 100 1000", got, ifc.cout, ifc.ovf, ifc.sum); end
    endtask

    task automatic test_sub();
        int bc; bit got;
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, bc, got);
        checks++; if ({got, ifc.cout, ifc.ovf, ifc.sum} !== {3'b100, 16'hFFFE}) begin errors++;
            $display("FAIL sub_borrow got %b%b%b %h want 100 fffe", got, ifc.cout, ifc.ovf, ifc.sum); end
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, bc, got);
        checks++; if ({got, ifc.cout, ifc.ovf, ifc.sum} !== {3'b111, EXP_8000_M1}) begin errors++;
            $display("FAIL sub_ovf got %b%b%b %h want 111 %h", got, ifc.cout, ifc.ovf, ifc.sum, EXP_8000_M1); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL sub_busy got %0d want 4", bc); end
    endtask

    task automatic test_ignore_start();
        int bc = 0; bit got = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 16'h0101; ifc.b = 16'h0202; ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (ifc.done) begin got = 1'b1; break; end
            if (ifc.busy) bc++;
            if (n == 1) begin ifc.start = 1'b1; ifc.sub = 1'b1; ifc.a = 16'hFFFF; ifc.b = 16'h1111; end
            else if (n == 2) ifc.start = 1'b0;
            @(negedge clk);
        end
        checks++; if (!got || bc !== 4) begin errors++; $display("FAIL ign_timing got done=%b busy=%0d want 1 4", got, bc); end
        checks++; if (ifc.sum !== 16'h0303) begin errors++; $display("FAIL ign_sum got %h want 0303", ifc.sum); end
        @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL ign_noqueue got busy=%b want 0", ifc.busy); end
    endtask

    task automatic test_back_to_back();
        int bc; bit got; int n = 0; bit got2 = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 16'h1111; ifc.b = 16'h2222; ifc.cin = 1'b0;
        bc = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.done) begin got = 1'b1; break; end
        end
        checks++; if (!got || ifc.sum !== 16'h3333) begin errors++; $display("FAIL b2b_first got done=%b sum=%h want 1 3333", got, ifc.sum); end
        ifc.a = 16'h8000; ifc.b = 16'hFFFF; ifc.cin = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) ifc.start = 1'b0;
            if (ifc.done) begin got2 = 1'b1; break; end
        end
        checks++; if (!got2 || n !== 5) begin errors++; $display("FAIL b2b_gap got done=%b gap=%0d want 1 5", got2, n); end
        checks++; if ({ifc.cout, ifc.ovf, ifc.sum} !== {2'b11, EXP_8000_PFF}) begin errors++;
            $display("FAIL b2b_second got %b%b %h want 11 %h", ifc.cout, ifc.ovf, ifc.sum, EXP_8000_PFF); end
    endtask

    task automatic test_reset_mid();
        int bc; bit got; bit seen = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.sub = 1'b0; ifc.a = 16'h0001; ifc.b = 16'h0001; ifc.cin = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got busy=%b want 1", ifc.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ifc.busy, ifc.done, ifc.cout, ifc.ovf, ifc.sum} !== 20'h0) begin errors++;
            $display("FAIL rmid_async got %b%b%b%b %h want 0000 0000", ifc.busy, ifc.done, ifc.cout, ifc.ovf, ifc.sum); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.done || ifc.busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_quiet got activity=%b want 0", seen); end
        run_op(1'b0, 16'hABCD, 16'h1111, 1'b0, bc, got);
        checks++; if ({got, ifc.sum} !== {1'b1, 16'hBCDE}) begin errors++;
            $display("FAIL rmid_after got %b %h want 1 bcde", got, ifc.sum); end
    endtask

    initial begin
        ifc.start = 1'b0; ifc.sub = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
